// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types for the MIPS core multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } muldiv_state_t;

endpackage
`default_nettype wire

// File: rtl/sign_adjust.sv
`default_nettype none
// ============================================================================
// Module      : sign_adjust
// Description : Optional two's-complement negation of a WIDTH-bit value.
// Revision    : 1.0 - initial release
// ============================================================================
module sign_adjust #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative multiply/divide unit owning the HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  muldiv_state_t        r_state, w_next_state;
  muldiv_op_t           r_op;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd, r_a_orig;
  logic                 r_neg_res, r_neg_rem;

  logic                 w_signed, w_is_div, w_run_div;
  logic [WIDTH-1:0]     w_a_abs, w_b_abs;
  logic [WIDTH:0]       w_mul_sum, w_div_shift, w_div_diff;
  logic [2*WIDTH-1:0]   w_mul_next, w_div_next, w_prod;
  logic [WIDTH-1:0]     w_quo, w_rem, w_hi_res, w_lo_res;

  assign w_signed  = op[0];
  assign w_is_div  = op[1];
  assign w_run_div = (r_op == DIVU) || (r_op == DIV);

  sign_adjust #(.WIDTH(WIDTH)) u_abs_a (
    .value(a), .negate(w_signed & a[WIDTH-1]), .result(w_a_abs));
  sign_adjust #(.WIDTH(WIDTH)) u_abs_b (
    .value(b), .negate(w_signed & b[WIDTH-1]), .result(w_b_abs));

  // Multiply: accumulator holds {partial product, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: accumulator holds {partial remainder, dividend/quotient bits}.
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_next  = w_div_diff[WIDTH] ?
                       {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0} :
                       {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  sign_adjust #(.WIDTH(2*WIDTH)) u_fix_prod (
    .value(r_acc), .negate(r_neg_res), .result(w_prod));
  sign_adjust #(.WIDTH(WIDTH)) u_fix_quo (
    .value(r_acc[WIDTH-1:0]), .negate(r_neg_res), .result(w_quo));
  sign_adjust #(.WIDTH(WIDTH)) u_fix_rem (
    .value(r_acc[2*WIDTH-1:WIDTH]), .negate(r_neg_rem), .result(w_rem));

  always_comb begin
    w_hi_res = w_prod[2*WIDTH-1:WIDTH];
    w_lo_res = w_prod[WIDTH-1:0];
    if (w_run_div) begin
      if (div_by_zero) begin
        w_hi_res = r_a_orig;
        w_lo_res = '1;
      end else begin
        w_hi_res = w_rem;
        w_lo_res = w_quo;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (r_cnt == LAST_ITER) w_next_state = FIX;
      FIX:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op        <= MULTU;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_a_orig    <= '0;
      r_neg_res   <= 1'b0;
      r_neg_rem   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op        <= muldiv_op_t'(op);
            r_cnt       <= '0;
            busy        <= 1'b1;
            div_by_zero <= w_is_div && (b == '0);
            r_a_orig    <= a;
            r_neg_res   <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_rem   <= w_signed & a[WIDTH-1];
            if (w_is_div) begin
              r_acc  <= {{WIDTH{1'b0}}, w_a_abs};
              r_opnd <= w_b_abs;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_b_abs};
              r_opnd <= w_a_abs;
            end
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= w_run_div ? w_div_next : w_mul_next;
        end
        FIX: begin
          hi   <= w_hi_res;
          lo   <= w_lo_res;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0, reset = 1'b1, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  // Reference: {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int sx, sy, q, r;
    sx = x;
    sy = y;
    case (o)
      2'd0: return {32'b0, x} * {32'b0, y};
      2'd1: begin p = longint'(sx) * longint'(sy); return p; end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (o == 2'd2) return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {r, q};
      end
    endcase
  endfunction

  // Starts an op and waits (bounded) for done; returns with #1 into the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic busy_ok, output logic busy_at_done);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1 lat++;
    end
    busy_at_done = busy;
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    n_tests++; if (hi !== '0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_tests++; if (lo !== '0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul();
    int lat; logic bok, bdone;
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok, bdone);
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL multu_latency got %0d want %0d", lat, LAT); end
    n_tests++; if (bok !== 1'b1) begin n_fail++; $display("FAIL multu_busy_run got %b want 1", bok); end
    n_tests++; if (bdone !== 1'b0) begin n_fail++; $display("FAIL multu_busy_done got %b want 0", bdone); end
    n_tests++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    n_tests++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", lo); end
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %b want 0", done); end
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, lat, bok, bdone);
    n_tests++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_tests++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
  endtask

  task automatic test_div();
    int lat; logic bok, bdone;
    run_op(2'd2, 32'd100, 32'd7, lat, bok, bdone);
    n_tests++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo got %h want 0000000e", lo); end
    n_tests++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi got %h want 00000002", hi); end
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, lat, bok, bdone);
    n_tests++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
    n_tests++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok, bdone);
    n_tests++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
    n_tests++; if (hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL div_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_div_by_zero();
    int lat; logic bok, bdone;
    run_op(2'd2, 32'd5, 32'd0, lat, bok, bdone);
    n_tests++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_lo got %h want ffffffff", lo); end
    n_tests++; if (hi !== 32'd5) begin n_fail++; $display("FAIL dbz_hi got %h want 00000005", hi); end
    n_tests++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag got %b want 1", div_by_zero); end
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL dbz_latency got %0d want %0d", lat, LAT); end
    run_op(2'd0, 32'd2, 32'd3, lat, bok, bdone);
    n_tests++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_clear got %b want 0", div_by_zero); end
    n_tests++; if (lo !== 32'd6) begin n_fail++; $display("FAIL dbz_next_lo got %h want 00000006", lo); end
  endtask

  task automatic test_moves();
    logic [W-1:0] hi_prev;
    int lat;
    hi_prev = hi;
    @(negedge clk); mtlo = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1 mtlo = 1'b0;
    n_tests++; if (lo !== 32'h1234) begin n_fail++; $display("FAIL mtlo got %h want 00001234", lo); end
    n_tests++; if (hi !== hi_prev) begin n_fail++; $display("FAIL mtlo_hi_kept got %h want %h", hi, hi_prev); end
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5555;
    @(posedge clk); #1 mthi = 1'b0; mtlo = 1'b0;
    n_tests++; if (hi !== 32'h5555) begin n_fail++; $display("FAIL mthi_both got %h want 00005555", hi); end
    n_tests++; if (lo !== 32'h5555) begin n_fail++; $display("FAIL mtlo_both got %h want 00005555", lo); end
    // start wins over a simultaneous move
    @(negedge clk); start = 1'b1; op = 2'd0; a = 32'd1; b = 32'd1; mthi = 1'b1; wdata = 32'h9999;
    @(posedge clk); #1 start = 1'b0; mthi = 1'b0;
    n_tests++; if (hi !== 32'h5555) begin n_fail++; $display("FAIL start_wins_hi got %h want 00005555", hi); end
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1 lat++; end
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL start_wins_latency got %0d want %0d", lat, LAT); end
    n_tests++; if ({hi, lo} !== 64'd1) begin n_fail++; $display("FAIL start_wins_result got %h want 1", {hi, lo}); end
  endtask

  task automatic test_ignore_busy();
    logic [W-1:0] hi_prev, lo_prev;
    logic [63:0] exp;
    int lat;
    hi_prev = hi; lo_prev = lo;
    exp = model(2'd1, 32'hFFFF_1234, 32'h0000_7654);
    @(negedge clk); start = 1'b1; op = 2'd1; a = 32'hFFFF_1234; b = 32'h0000_7654;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    repeat (5) begin @(posedge clk); #1 lat++; end
    @(negedge clk); start = 1'b1; op = 2'd2; a = 32'd99; b = 32'd3; mthi = 1'b1; wdata = 32'hAAAA;
    @(posedge clk); #1 lat++; start = 1'b0; mthi = 1'b0;
    n_tests++; if ({hi, lo} !== {hi_prev, lo_prev}) begin n_fail++; $display("FAIL run_hilo_hold got %h want %h", {hi, lo}, {hi_prev, lo_prev}); end
    while (!done && lat < 100) begin @(posedge clk); #1 lat++; end
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL ignore_latency got %0d want %0d", lat, LAT); end
    n_tests++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL ignore_result got %h want %h", {hi, lo}, exp); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_queue got %b want 0", busy); end
  endtask

  task automatic test_abort();
    int lat; logic bok, bdone;
    @(negedge clk); start = 1'b1; op = 2'd0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    n_tests++; if ({busy, done, div_by_zero} !== 3'b000) begin n_fail++; $display("FAIL abort_flags got %b want 000", {busy, done, div_by_zero}); end
    n_tests++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL abort_hilo got %h want 0", {hi, lo}); end
    @(negedge clk); reset = 1'b0;
    run_op(2'd0, 32'd4, 32'd5, lat, bok, bdone);
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL abort_next_latency got %0d want %0d", lat, LAT); end
    n_tests++; if ({hi, lo} !== 64'd20) begin n_fail++; $display("FAIL abort_next_result got %h want 20", {hi, lo}); end
  endtask

  task automatic test_back_to_back();
    int lat; logic bok, bdone;
    logic [1:0] o;
    logic [31:0] x, y;
    logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = $urandom_range(0, 300); y = $urandom_range(1, 20); end
        3: y = -$urandom_range(1, 20);
        default: ;
      endcase
      exp = model(o, x, y);
      run_op(o, x, y, lat, bok, bdone);
      n_tests++; if ({hi, lo} !== exp) begin n_fail++; $display("FAIL rand_%0d op%0d a=%h b=%h got %h want %h", i, o, x, y, {hi, lo}, exp); end
      n_tests++; if (div_by_zero !== (o[1] && y == 0)) begin n_fail++; $display("FAIL rand_dbz_%0d got %b want %b", i, div_by_zero, (o[1] && y == 0)); end
      n_tests++; if (lat !== LAT || bok !== 1'b1 || bdone !== 1'b0) begin n_fail++; $display("FAIL rand_timing_%0d lat %0d busy_run %b busy_done %b want %0d 1 0", i, lat, bok, bdone, LAT); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_moves();
    test_ignore_busy();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
